// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ requesters.
// The winning write is registered onto the port one cycle after acceptance; x0 writes are dropped.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic                         wp_stall,
    output logic                         wp_wen,
    output logic [ADDR_W-1:0]            wp_addr,
    output logic [DATA_W-1:0]            wp_data,
    output logic [$clog2(NUM_REQ)-1:0]   wp_src,
    output logic [CNT_W-1:0]             write_count
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);
    localparam int unsigned SUM_W = SRC_W + 1;

    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 wen_q, wen_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [SRC_W-1:0]     src_q, src_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic                 found;
    logic [SRC_W-1:0]     offset;
    logic [SUM_W-1:0]     idx_sum;
    logic [SRC_W-1:0]     grant_idx;
    logic                 fire;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;

    // Rotate requests so the search starts at rr_ptr, then map the first hit back to a requester index.
    always_comb begin
        valid_dbl = {req_valid, req_valid};
        valid_rot = NUM_REQ'(valid_dbl >> rr_ptr_q);
        found     = 1'b0;
        offset    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && valid_rot[k]) begin
                found  = 1'b1;
                offset = SRC_W'(k);
            end
        end
        idx_sum   = SUM_W'(rr_ptr_q) + SUM_W'(offset);
        grant_idx = (idx_sum >= SUM_W'(NUM_REQ)) ? SRC_W'(idx_sum - SUM_W'(NUM_REQ))
                                                 : SRC_W'(idx_sum);
        fire      = found && rst && !wp_stall;
    end

    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = fire && (grant_idx == SRC_W'(i));
            if (grant_idx == SRC_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wen_d    = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        src_d    = src_q;
        cnt_d    = wen_q ? cnt_q + CNT_W'(1) : cnt_q;
        if (fire) begin
            rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : SRC_W'(grant_idx + SRC_W'(1));
            wen_d    = (sel_addr != '0);
            addr_d   = sel_addr;
            data_d   = sel_data;
            src_d    = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wp_wen      = wen_q;
    assign wp_addr     = addr_q;
    assign wp_data     = data_q;
    assign wp_src      = src_q;
    assign write_count = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (2 requesters, 4-bit counter to exercise wrap).
module tb_regfile_write_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic                       wp_stall;
    logic                       wp_wen;
    logic [ADDR_W-1:0]          wp_addr;
    logic [DATA_W-1:0]          wp_data;
    logic [0:0]                 wp_src;
    logic [CNT_W-1:0]           write_count;

    int n_chk = 0;
    int n_bad = 0;

    regfile_write_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .wp_stall(wp_stall),
        .wp_wen(wp_wen), .wp_addr(wp_addr), .wp_data(wp_data),
        .wp_src(wp_src), .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic chk_wp(input string tag, input logic wen, input logic [4:0] a,
                          input logic [31:0] d, input logic s);
        chk({tag, ".wen"},  32'(wp_wen),  32'(wen));
        chk({tag, ".addr"}, 32'(wp_addr), 32'(a));
        chk({tag, ".data"}, wp_data,      d);
        chk({tag, ".src"},  32'(wp_src),  32'(s));
    endtask

    // Requester obligation: a pending request must hold valid, addr and data until accepted.
    logic [NUM_REQ-1:0]        pend = '0;
    logic [NUM_REQ*ADDR_W-1:0] addr_h = '0;
    logic [NUM_REQ*DATA_W-1:0] data_h = '0;
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend[i]) begin
                    chk("proto_valid", 32'(req_valid[i]), 32'd1);
                    chk("proto_addr", 32'(req_addr[i*ADDR_W +: ADDR_W]), 32'(addr_h[i*ADDR_W +: ADDR_W]));
                    chk("proto_data", req_data[i*DATA_W +: DATA_W], data_h[i*DATA_W +: DATA_W]);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++)
            pend[i] <= rst && req_valid[i] && !req_ready[i];
        addr_h <= req_addr;
        data_h <= req_data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: ready gated off even with requests present
        rst = 1'b0;
        wp_stall = 1'b0;
        set_req(2'b11, 5'd5, 32'h1, 5'd6, 32'h2);
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        chk_wp("rst", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rst_cnt", 32'(write_count), 32'd0);

        // T1 single write
        rst = 1'b1;
        set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        #1 chk("t1_ready", 32'(req_ready), 32'd1);
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk_wp("t1_wr", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        chk("t1_cnt0", 32'(write_count), 32'd0);
        step();
        chk("t1_wen_off", 32'(wp_wen), 32'd0);
        chk("t1_cnt", 32'(write_count), 32'd1);

        // T2 contention from a fresh pointer: grants 0,1,0,1
        rst = 1'b0;
        step();
        rst = 1'b1;
        set_req(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
        for (int k = 0; k < 4; k++) begin
            #1 chk("t2_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            step();
            chk_wp("t2_wr", 1'b1, (k % 2 == 0) ? 5'd1 : 5'd2,
                   (k % 2 == 0) ? 32'h11 : 32'h22, (k % 2 == 0) ? 1'b0 : 1'b1);
        end
        chk("t2_cnt3", 32'(write_count), 32'd3);
        set_req(2'b01, 5'd1, 32'h11, 5'd2, 32'h22);
        #1 chk("t2_ready5", 32'(req_ready), 32'd1);
        step();
        chk("t2_cnt4", 32'(write_count), 32'd4);
        chk_wp("t2_wr5", 1'b1, 5'd1, 32'h11, 1'b0);

        // T3 x0 write from req1: accepted, no enable, pointer wraps to 0
        set_req(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234);
        #1 chk("t3_ready", 32'(req_ready), 32'd2);
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk_wp("t3_x0", 1'b0, 5'd0, 32'h1234, 1'b1);
        chk("t3_cnt", 32'(write_count), 32'd5);
        step();
        chk("t3_wen", 32'(wp_wen), 32'd0);
        chk("t3_cnt_hold", 32'(write_count), 32'd5);
        set_req(2'b11, 5'd3, 32'h33, 5'd4, 32'h44);
        #1 chk("t3_ptr_wrap", 32'(req_ready), 32'd1);
        step();
        chk_wp("t3_pair0", 1'b1, 5'd3, 32'h33, 1'b0);
        set_req(2'b10, 5'd3, 32'h33, 5'd4, 32'h44);
        #1 chk("t3_pair_ready1", 32'(req_ready), 32'd2);
        step();
        chk_wp("t3_pair1", 1'b1, 5'd4, 32'h44, 1'b1);
        chk("t3_cnt6", 32'(write_count), 32'd6);

        // T4 stall: an already-registered write survives, grants blocked for 3 cycles
        set_req(2'b01, 5'd7, 32'h77, 5'd0, 32'h0);
        wp_stall = 1'b1;
        chk("t4_wen_kept", 32'(wp_wen), 32'd1);
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_ready", 32'(req_ready), 32'd0);
            step();
            chk("t4_wen", 32'(wp_wen), 32'd0);
        end
        chk("t4_cnt", 32'(write_count), 32'd7);
        wp_stall = 1'b0;
        #1 chk("t4_release", 32'(req_ready), 32'd1);
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk_wp("t4_wr", 1'b1, 5'd7, 32'h77, 1'b0);
        step();
        chk("t4_cnt8", 32'(write_count), 32'd8);

        // T5 reset right after a fire drops the presented write and the count
        set_req(2'b01, 5'd12, 32'hC, 5'd0, 32'h0);
        step();
        chk("t5_fire", 32'(wp_wen), 32'd1);
        rst = 1'b0;
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        chk_wp("t5_rst", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("t5_cnt", 32'(write_count), 32'd0);
        rst = 1'b1;
        set_req(2'b10, 5'd0, 32'h0, 5'd6, 32'h66);
        #1 chk("t5_ready", 32'(req_ready), 32'd2);
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk_wp("t5_wr", 1'b1, 5'd6, 32'h66, 1'b1);
        step();
        chk("t5_cnt1", 32'(write_count), 32'd1);

        // T6 17 back-to-back writes on a 4-bit counter
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 17; k++) begin
            set_req(2'b01, 5'(k + 1), 32'(k), 5'd0, 32'h0);
            step();
            chk("t6_wen", 32'(wp_wen), 32'd1);
            chk("t6_addr", 32'(wp_addr), 32'(k + 1));
        end
        chk("t6_cnt16", 32'(write_count), 32'd0);
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        chk("t6_cnt17", 32'(write_count), 32'd1);
        chk("t6_wen_off", 32'(wp_wen), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ requesters, e.g. the writeback commit path and a debug/loader port.
- Each requester uses a valid/ready handshake.
- Grants are round-robin, and the winning write is registered onto the port one cycle later.
- Writes to x0 are suppressed, and a retired-write counter is kept.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 5, register address width
DATA_W, 32, write data width
CNT_W, 32, retired-write counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed data, same packing
wp_stall  input  1  write port unavailable this cycle, blocks all grants
wp_wen  output  1  register-file write enable
wp_addr  output  ADDR_W  register-file write address
wp_data  output  DATA_W  register-file write data
wp_src  output  $clog2(NUM_REQ)  index of requester that owns the current wp_* write
write_count  output  CNT_W  number of writes actually performed (wp_wen=1)

Behaviour:
Reset (rst=0 at a rising edge):
- wp_wen=0, wp_addr=0, wp_data=0, wp_src=0, write_count=0, rr_ptr=0.
- A write registered but not yet presented is dropped.
- req_ready=0 while rst=0.

Arbitration (combinational, same cycle):
- If wp_stall=1, all req_ready=0.
- Otherwise grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
- req_ready[i]=1 only for the granted i. req_ready never depends on any requester's ready.
- fire = req_valid[g] & req_ready[g].

Pointer:
- On fire, rr_ptr <= (g+1) mod NUM_REQ.
- With no fire, rr_ptr holds.
- Wrap-around: g = NUM_REQ-1 gives rr_ptr = 0.

Output stage (latency 1, no storage beyond one register set):
- On fire: wp_addr <= req_addr[g], wp_data <= req_data[g], wp_src <= g, wp_wen <= (req_addr[g] != 0).
- With no fire: wp_wen <= 0, and wp_addr, wp_data and wp_src hold their last values.
- wp_wen is a single-cycle pulse per accepted request. Back-to-back fires give back-to-back pulses (full throughput, one write per cycle).
- x0 write: the request is accepted (ready=1, pointer advances), wp_wen stays 0, and the counter does not increment.

Counter:
- write_count <= write_count + 1 on every cycle where wp_wen=1.
- Wraps modulo 2^CNT_W and does not saturate.

Requester obligations (checked by assertions in the bench):
- Once req_valid[i]=1, it stays high with stable addr/data until req_ready[i]=1.
- The arbiter stays correct if this is violated, but the bench flags the violation.

Simultaneous events:
- wp_stall=1 with all requesters valid: no grant, and the pointer and outputs' valid state follow the "with no fire" rule.
- A grant in the same cycle that the stall deasserts is allowed (the stall is sampled combinationally).
- A stall does not cancel a wp_wen already registered from the previous cycle.

Mid-operation reset:
- A reset at the same edge as a fire wins. No write appears and the pointer returns to 0.

Test Plan:
1. Reset then single write: rst=0 for 2 cycles, then req0 valid with addr=5, data=0xDEADBEEF -> req_ready=01 that cycle; next cycle wp_wen=1, wp_addr=5, wp_data=0xDEADBEEF, wp_src=0; the cycle after, wp_wen=0 and write_count=1.
2. Contention round-robin: both requesters valid continuously for 4 cycles (req0 addr=1, req1 addr=2) -> grants 0,1,0,1; wp_addr sequence 1,2,1,2 on consecutive cycles; write_count=4.
3. x0 suppression: req1 writes addr=0, data=0x1234 -> req_ready[1]=1, rr_ptr goes 1->0 (wrap), wp_wen stays 0, write_count unchanged.
4. Stall: wp_stall=1 for 3 cycles with req0 valid (addr=7) -> req_ready=0 and wp_wen=0 for all 3 cycles; on stall release, grant in that cycle and wp_addr=7 with wp_wen=1 one cycle later.
5. Reset mid-flight: req0 fires at edge N, and rst=0 is sampled at edge N+1 -> wp_wen=0 after edge N+1, write_count=0, rr_ptr=0; a subsequent req1-only request is granted normally.
6. Counter wrap (CNT_W=4 build): 17 nonzero-address writes -> write_count reads 1.
